fifo_word_serializer: RTL
=========================

Name: fifo_word_serializer

Overview:
- Downstream stage of the parametrical FIFO.
- Pops WORD_WIDTH-bit words from the FIFO's read side and emits them as RATIO = WORD_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream.
- Flags the final beat of each word.
- Sustains one beat per cycle with no bubble between consecutive words when the FIFO is non-empty.

Parameters:
- WORD_WIDTH, 32, width of FIFO read data; must equal the FIFO's WIDTH.
- OUT_WIDTH, 8, width of each output beat; WORD_WIDTH must be an integer multiple ≥2 of OUT_WIDTH (elaboration error otherwise).
- MSB_FIRST, 1, 1 = most significant slice emitted first; 0 = least significant slice first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- fifoEmpty  input  1  FIFO empty flag.
- fifoReadData  input  WORD_WIDTH  FIFO head word; valid whenever fifoEmpty=0 (first-word-fall-through).
- fifoReadEnable  output  1  pop request; FIFO advances readPtr at the same rising edge.
- outData  output  OUT_WIDTH  current beat.
- outValid  output  1  beat valid.
- outReady  input  1  sink accepts beat.
- outLast  output  1  high with the final beat of a word.
- wordCount  output  16  count of words fully emitted since reset; wraps 0xFFFF→0x0000.

Behaviour:
- Single clock domain; reset is synchronous and active-high, sampled at the rising edge of clk. No asynchronous paths.
- Internal state:
  - holdReg (WORD_WIDTH)
  - beatCnt (clog2(RATIO) bits)
  - holding flag
  - wordCount
- Reset values: holding=0, beatCnt=0, holdReg=0, wordCount=0.
  - Hence outValid=0, outLast=0, outData=0.
  - fifoReadEnable is forced 0 while reset=1.
- FSM, two states:
  - EMPTY (holding=0)
  - HOLD (holding=1)
- Definitions:
  - accept = outValid & outReady.
  - lastAccept = accept & (beatCnt == RATIO-1).
- fifoReadEnable (combinational) = !reset & !fifoEmpty & (state==EMPTY | lastAccept). Never asserted while fifoEmpty=1.
- On fifoReadEnable at a rising edge: holdReg <= fifoReadData, beatCnt <= 0, state <= HOLD.
- Latency: word visible at FIFO head in cycle N → first beat on outData/outValid in cycle N+1.
- outValid = (state==HOLD).
- outData:
  - MSB_FIRST=1: holdReg[WORD_WIDTH-1-beatCnt*OUT_WIDTH -: OUT_WIDTH].
  - MSB_FIRST=0: holdReg[beatCnt*OUT_WIDTH +: OUT_WIDTH].
- outLast = outValid & (beatCnt == RATIO-1).
- Handshake rules:
  - While outValid=1 and outReady=0, outData, outLast and beatCnt hold stable.
  - Non-last accept: beatCnt <= beatCnt+1.
  - lastAccept with fifoEmpty=0: reload next word in the same edge; stays HOLD, beatCnt <= 0 (zero-bubble back-to-back).
  - lastAccept with fifoEmpty=1: state <= EMPTY, beatCnt <= 0.
- wordCount increments by 1 on every lastAccept. Wraps modulo 2^16.
- Boundaries:
  - FIFO empty in EMPTY: remain idle, no pop.
  - outReady held low: never pops more than one word ahead (at most one word buffered internally).
  - Reset mid-word: the partially emitted word is discarded. The word is already popped, so it is lost; this is the accepted, documented behaviour.
  - outReady high with outValid=0 has no effect.

Test Plan:
- Reset, FIFO empty 10 cycles → outValid=0, fifoReadEnable=0, wordCount=0 throughout.
- Push 0xA1B2C3D4, outReady=1, MSB_FIRST=1 → beats 0xA1, 0xB2, 0xC3, 0xD4 on 4 consecutive cycles; outLast only on 0xD4; single fifoReadEnable pulse; wordCount=1.
- Push 0x11223344 and 0x55667788 back-to-back, outReady=1 → 8 consecutive valid beats 0x11..0x88, no idle cycle; second fifoReadEnable coincides with the 0x44 accept; wordCount=2.
- Word 0xDEADBEEF, outReady toggles 1,0,0,1,1,0,1 → outData frozen on each stall; sequence DE, AD, BE, EF; no extra pops while stalled.
- MSB_FIRST=0, word 0x01020304 → beats 0x04, 0x03, 0x02, 0x01.
- Assert reset after 2 beats of 0xCAFEF00D → next cycle outValid=0, beatCnt=0, wordCount=0. The next FIFO word emits from its first beat.

Source files
------------

// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
// Pops WORD_WIDTH-bit words from a first-word-fall-through FIFO and emits them
// as RATIO narrow beats on a valid/ready stream. The last beat of each word is
// flagged. A new word is reloaded on the same edge that accepts the previous
// word's last beat, so consecutive words stream without a bubble.
module fifo_word_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifoEmpty,
    input  logic [WORD_WIDTH-1:0] fifoReadData,
    output logic                  fifoReadEnable,
    output logic [OUT_WIDTH-1:0]  outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  outLast,
    output logic [15:0]           wordCount
);

    localparam int RATIO = WORD_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    // Reject geometries where a word cannot be split into two or more equal beats.
    if ((OUT_WIDTH < 1) || (WORD_WIDTH % OUT_WIDTH != 0) || (RATIO < 2)) begin : g_bad_geometry
        $error("fifo_word_serializer: WORD_WIDTH must be an integer multiple >= 2 of OUT_WIDTH");
    end

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                           r_state;
    logic [WORD_WIDTH-1:0]            r_holdReg;
    logic [CNT_W-1:0]                 r_beatCnt;
    logic [15:0]                      r_wordCount;

    logic                             w_accept;
    logic                             w_lastBeat;
    logic                             w_lastAccept;
    logic                             w_pop;
    logic [CNT_W-1:0]                 w_sel;
    logic [RATIO-1:0][OUT_WIDTH-1:0]  w_slices;

    // Handshake decode. Only a held word can be accepted, so outReady alone
    // does nothing while idle.
    assign w_lastBeat   = (r_beatCnt == LAST_BEAT);
    assign w_accept     = (r_state == S_HOLD) & outReady;
    assign w_lastAccept = w_accept & w_lastBeat;

    // Pop when idle, or when the held word is leaving this cycle. This keeps at
    // most one word buffered internally however long the sink stalls.
    assign w_pop = !reset & !fifoEmpty & ((r_state == S_EMPTY) | w_lastAccept);

    // Beat selection: view the held word as RATIO slices, slice 0 least significant.
    assign w_slices = r_holdReg;

    if (MSB_FIRST) begin : g_msb_first
        assign w_sel = LAST_BEAT - r_beatCnt;
    end else begin : g_lsb_first
        assign w_sel = r_beatCnt;
    end

    assign fifoReadEnable = w_pop;
    assign outValid       = (r_state == S_HOLD);
    assign outData        = w_slices[w_sel];
    assign outLast        = (r_state == S_HOLD) & w_lastBeat;
    assign wordCount      = r_wordCount;

    // Serializer FSM: load a word, step through its beats, reload or go idle on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            // A word caught mid-emission is dropped; it has already left the FIFO.
            r_state     <= S_EMPTY;
            r_holdReg   <= '0;
            r_beatCnt   <= '0;
            r_wordCount <= '0;
        end else begin
            if (w_pop) begin
                r_holdReg <= fifoReadData;
                r_beatCnt <= '0;
                r_state   <= S_HOLD;
            end else if (w_lastAccept) begin
                r_beatCnt <= '0;
                r_state   <= S_EMPTY;
            end else if (w_accept) begin
                r_beatCnt <= r_beatCnt + CNT_W'(1);
            end

            if (w_lastAccept) begin
                r_wordCount <= r_wordCount + 16'd1;
            end
        end
    end

endmodule
